// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the capture BRAM arbiter and its
// neighbouring capture / FFT blocks.
package bram_arb_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 24;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD       = 2'd2,
    ST_RD_BURST = 2'd3
  } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter_read_pipe.sv
// Read return path: rd_ack in the cycle after a read grant, then rd_valid with
// the captured BRAM word one cycle later.
module arb_read_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  grant,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_ack   <= grant;
      rd_valid <= rd_ack;
      // mem_addr was registered on the grant edge, so mem_rdata holds the word now
      if (rd_ack) rd_data <= mem_rdata;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates one single-port capture BRAM between the sample writer and the FFT
// reader. Optional statistics outputs are enabled with `define ARB_STATS_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic                  rd_burst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  wr_stall
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           stat_conflicts,
  output logic [15:0]           stat_forced
`endif
);

  localparam int unsigned      CNT_W      = ADDR_WIDTH + 1;
  localparam logic [3:0]       WAIT_MAX   = 4'(MAX_WAIT);
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_LEN - 1);
  localparam bit               BURST_ON   = (BURST_LEN > 1);

  arb_state_t       state, state_next;
  logic [3:0]       wait_cnt, wait_next;
  logic [CNT_W-1:0] burst_cnt, burst_next;
  logic             grant_wr, grant_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      burst_cnt <= burst_next;
    end
  end

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    wait_next  = wait_cnt;
    if (!rd_req || grant_rd) wait_next = '0;
    else if (wait_cnt != WAIT_MAX) wait_next = wait_cnt + 4'd1;
    case (state)
      ST_RD_BURST: begin
        // The entry grant already used one slot, so BURST_LEN-1 remain
        if (grant_rd) begin
          if (burst_cnt <= CNT_W'(1)) begin
            state_next = ST_IDLE;
            burst_next = '0;
          end else begin
            burst_next = burst_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        if (grant_wr) begin
          state_next = ST_WR;
        end else if (grant_rd) begin
          if (rd_burst && BURST_ON) begin
            state_next = ST_RD_BURST;
            burst_next = BURST_LOAD;
          end else begin
            state_next = ST_RD;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == ST_RD_BURST) grant_rd = rd_req;
    else if (rd_req && (!wr_req || wait_cnt == WAIT_MAX)) grant_rd = 1'b1;
    else grant_wr = wr_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_stall  <= 1'b0;
    end else begin
      mem_we   <= grant_wr;
      wr_ack   <= grant_wr;
      wr_stall <= wr_req && !grant_wr;
      if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (grant_rd) begin
        mem_addr <= rd_addr;
      end
    end
  end

  arb_read_pipe #(.WORD_WIDTH(WORD_WIDTH)) u_read_pipe (
    .clk       (clk),
    .reset     (reset),
    .grant     (grant_rd),
    .mem_rdata (mem_rdata),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

`ifdef ARB_STATS_EN
  logic conflict, forced;
  assign conflict = wr_req && rd_req;
  assign forced   = grant_rd && wr_req && (state != ST_RD_BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_conflicts <= '0;
      stat_forced    <= '0;
    end else begin
      if (conflict && stat_conflicts != '1) stat_conflicts <= stat_conflicts + 16'd1;
      if (forced && stat_forced != '1) stat_forced <= stat_forced + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural BRAM
// whose registered address is the arbiter's mem_addr.
module tb_bram_port_arbiter;

  localparam int unsigned WW = 24;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req, rd_burst;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [WW-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_valid, mem_we, wr_stall;
  logic [WW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [WW-1:0] mem [8];

  int vectors     = 0;
  int miscompares = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  bram_port_arbiter #(
    .WORD_WIDTH (WW),
    .ADDR_WIDTH (AW),
    .MAX_WAIT   (4),
    .BURST_LEN  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_burst  (rd_burst),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wr_stall  (wr_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; rd_burst = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_stall", 32'(wr_stall), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    tick();

    // single write to addr 3
    wr_req = 1'b1; wr_addr = 3'd3; wr_data = 24'hABCDEF;
    tick();
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 3);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hABCDEF);
    chk("wr_ack", 32'(wr_ack), 1);
    chk("wr_no_rd_ack", 32'(rd_ack), 0);
    chk("wr_no_stall", 32'(wr_stall), 0);
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 3'd3;
    tick();
    chk("raw_wr_ack_once", 32'(wr_ack), 0);
    chk("raw_mem_we", 32'(mem_we), 0);
    chk("raw_rd_ack", 32'(rd_ack), 1);
    chk("raw_mem_addr", 32'(mem_addr), 3);
    chk("raw_no_valid_yet", 32'(rd_valid), 0);
    rd_req = 1'b0;
    tick();
    chk("raw_rd_ack_once", 32'(rd_ack), 0);
    chk("raw_rd_valid", 32'(rd_valid), 1);
    chk("raw_rd_data", 32'(rd_data), 32'hABCDEF);
    tick();
    chk("raw_valid_pulse", 32'(rd_valid), 0);

    // contention: 4 writes, 1 forced read, writes resume
    wr_req = 1'b1; wr_addr = 3'd5; wr_data = 24'h111111;
    rd_req = 1'b1; rd_addr = 3'd3;
    stall_cycles = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("cont_wr_ack_%0d", k), 32'(wr_ack), (k == 5) ? 0 : 1);
      chk($sformatf("cont_rd_ack_%0d", k), 32'(rd_ack), (k == 5) ? 1 : 0);
      chk($sformatf("cont_mem_we_%0d", k), 32'(mem_we), (k == 5) ? 0 : 1);
      if (wr_stall) stall_cycles++;
    end
    chk("cont_rd_valid", 32'(rd_valid), 1);
    chk("cont_rd_data", 32'(rd_data), 32'hABCDEF);
    chk("cont_stall_cycles", 32'(stall_cycles), 1);
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    chk("cont_drop_no_ack", 32'(rd_ack), 0);

    // back-to-back writes fill addr 0..7
    wr_req = 1'b1; wr_addr = 3'd0; wr_data = 24'hC00000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fill_ack_%0d", i), 32'(wr_ack), 1);
      chk($sformatf("fill_addr_%0d", i), 32'(mem_addr), 32'(i));
      wr_addr = 3'((i + 1) % 8);
      wr_data = 24'hC00000 + 24'(i + 1);
    end
    wr_req = 1'b0;

    // burst of 8 reads with the writer waiting
    rd_req = 1'b1; rd_burst = 1'b1; rd_addr = 3'd0;
    tick();
    chk("burst_rd_ack_1", 32'(rd_ack), 1);
    chk("burst_addr_1", 32'(mem_addr), 0);
    wr_req = 1'b1; wr_addr = 3'd6; wr_data = 24'h777777;
    rd_burst = 1'b0; rd_addr = 3'd1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("burst_rd_ack_%0d", k), 32'(rd_ack), 1);
      chk($sformatf("burst_wr_ack_%0d", k), 32'(wr_ack), 0);
      chk($sformatf("burst_addr_%0d", k), 32'(mem_addr), 32'(k - 1));
      chk($sformatf("burst_valid_%0d", k), 32'(rd_valid), 1);
      chk($sformatf("burst_data_%0d", k), 32'(rd_data), 32'hC00000 + 32'(k - 2));
      chk($sformatf("burst_stall_%0d", k), 32'(wr_stall), 1);
      rd_addr = 3'(k % 8);
    end
    rd_req = 1'b0;
    tick();
    chk("burst_end_wr_ack", 32'(wr_ack), 1);
    chk("burst_end_rd_ack", 32'(rd_ack), 0);
    chk("burst_end_data", 32'(rd_data), 32'hC00007);
    chk("burst_end_mem_addr", 32'(mem_addr), 6);
    wr_req = 1'b0;
    tick();
    chk("burst_post_stall", 32'(wr_stall), 0);
    chk("burst_post_valid", 32'(rd_valid), 0);

    // reset after the third burst read
    rd_req = 1'b1; rd_burst = 1'b1; rd_addr = 3'd0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("rstb_rd_ack_%0d", k), 32'(rd_ack), 1);
      rd_addr = 3'(k);
    end
    reset = 1'b1; wr_req = 1'b1; wr_addr = 3'd2; wr_data = 24'h5A5A5A;
    tick();
    chk("rstb_rd_ack", 32'(rd_ack), 0);
    chk("rstb_rd_valid", 32'(rd_valid), 0);
    chk("rstb_mem_we", 32'(mem_we), 0);
    chk("rstb_mem_addr", 32'(mem_addr), 0);
    chk("rstb_rd_data", 32'(rd_data), 0);
    chk("rstb_wr_stall", 32'(wr_stall), 0);
    reset = 1'b0;
    tick();
    chk("rstb_wr_ack", 32'(wr_ack), 1);
    chk("rstb_mem_we_after", 32'(mem_we), 1);
    chk("rstb_mem_addr_after", 32'(mem_addr), 2);
    chk("rstb_no_rd_ack", 32'(rd_ack), 0);
    wr_req = 1'b0; rd_req = 1'b0; rd_burst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
